pipe_ctrl: RTL and testbench

- Central hazard and sequencing controller for the RV32I pipeline (pc → if_id → id → id_ex → ex → mem).
- Observes decode read addresses, the ex-stage write target, the jump request from ex, the data-bus busy signal and multi-cycle-op handshakes.
- Drives per-stage hold and flush controls and the redirected jump target.
- Keeps a stall-cycle performance counter and flags a multi-cycle timeout.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold encodings, bus types and controller states.
package pipe_ctrl_pkg;

  typedef logic [2:0]  hold_flag_bus_t;
  typedef logic [4:0]  reg_addr_bus_t;
  typedef logic [31:0] word_t;

  // bit0 pc, bit1 if_id, bit2 id_ex
  localparam hold_flag_bus_t Hold_None  = 3'b000;
  localparam hold_flag_bus_t Hold_Front = 3'b011;
  localparam hold_flag_bus_t Hold_All   = 3'b111;

  localparam reg_addr_bus_t ZeroReg  = 5'd0;
  localparam word_t         ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_LOAD_BUB = 2'd1,
    CTRL_MC_WAIT  = 2'd2
  } ctrl_state_e;

  function automatic logic hold_active(input hold_flag_bus_t hold);
    return hold != Hold_None;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Pure combinational load-use compare between the ex-stage load target and decode reads.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  reg_addr_bus_t i_id_reg1_raddr,
  input  reg_addr_bus_t i_id_reg2_raddr,
  input  logic          i_ex_reg_we,
  input  reg_addr_bus_t i_ex_reg_waddr,
  input  logic          i_ex_is_load,
  output logic          o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = (i_ex_reg_waddr == i_id_reg1_raddr);
  assign w_rs2_hit = (i_ex_reg_waddr == i_id_reg2_raddr);

  // x0 is never a real dependency, so a zero target cannot create a hazard.
  assign o_load_use = i_ex_is_load && i_ex_reg_we && (i_ex_reg_waddr != ZeroReg) &&
                      (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller: per-stage hold/flush, jump redirect, multi-cycle wait,
// stall-cycle counter and multi-cycle timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_reg1_raddr_i,
  input  logic [4:0]       id_reg2_raddr_i,
  input  logic             ex_reg_we_i,
  input  logic [4:0]       ex_reg_waddr_i,
  input  logic             ex_is_load_i,
  input  logic             ex_jump_flag_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             ex_mc_start_i,
  input  logic             ex_mc_done_i,
  input  logic             mem_busy_i,
  output logic [2:0]       hold_flag_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic             mc_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned   TmoW    = $clog2(MC_TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MC_TIMEOUT - 1);

  ctrl_state_e     r_state;
  ctrl_state_e     w_state_nxt;
  logic [TmoW-1:0] r_tmo;
  logic [TmoW-1:0] w_tmo_nxt;
  logic            r_mc_timeout;
  logic            w_mc_timeout_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic            w_load_use;
  hold_flag_bus_t  w_hold;
  logic            w_flush_if_id;
  logic            w_flush_id_ex;
  logic            w_jump;
  word_t           w_jump_addr;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .i_id_reg1_raddr (id_reg1_raddr_i),
    .i_id_reg2_raddr (id_reg2_raddr_i),
    .i_ex_reg_we     (ex_reg_we_i),
    .i_ex_reg_waddr  (ex_reg_waddr_i),
    .i_ex_is_load    (ex_is_load_i),
    .o_load_use      (w_load_use)
  );

  always_comb begin
    w_hold           = Hold_None;
    w_flush_if_id    = 1'b0;
    w_flush_id_ex    = 1'b0;
    w_jump           = 1'b0;
    w_jump_addr      = ZeroWord;
    w_state_nxt      = r_state;
    w_tmo_nxt        = r_tmo;
    w_mc_timeout_nxt = 1'b0;

    if (mem_busy_i) begin
      // Data-bus stall freezes everything, including pending ex events.
      w_hold = Hold_All;
    end else begin
      case (r_state)
        CTRL_RUN: begin
          if (ex_jump_flag_i) begin
            w_jump        = 1'b1;
            w_jump_addr   = ex_jump_addr_i;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
          end else if (ex_mc_start_i) begin
            w_state_nxt = CTRL_MC_WAIT;
            w_tmo_nxt   = '0;
          end else if (w_load_use) begin
            w_hold        = Hold_Front;
            w_flush_id_ex = 1'b1;
            w_state_nxt   = CTRL_LOAD_BUB;
          end
        end
        CTRL_LOAD_BUB: begin
          if (ex_jump_flag_i) begin
            w_jump        = 1'b1;
            w_jump_addr   = ex_jump_addr_i;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
          end
          w_state_nxt = CTRL_RUN;
        end
        CTRL_MC_WAIT: begin
          if (ex_mc_done_i) begin
            w_state_nxt = CTRL_RUN;
          end else if (r_tmo == TmoLast) begin
            // Abort: drop the stuck op from id_ex and report it next cycle.
            w_flush_id_ex    = 1'b1;
            w_state_nxt      = CTRL_RUN;
            w_mc_timeout_nxt = 1'b1;
          end else begin
            w_hold    = Hold_All;
            w_tmo_nxt = r_tmo + TmoW'(1);
          end
        end
        default: w_state_nxt = CTRL_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= CTRL_RUN;
      r_tmo        <= '0;
      r_mc_timeout <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmo        <= w_tmo_nxt;
      r_mc_timeout <= w_mc_timeout_nxt;
      if (hold_active(w_hold)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Reset must drop holds and redirects immediately, not at the next edge.
  assign hold_flag_o   = rst ? Hold_None : w_hold;
  assign flush_if_id_o = rst ? 1'b0 : w_flush_if_id;
  assign flush_id_ex_o = rst ? 1'b0 : w_flush_id_ex;
  assign jump_flag_o   = rst ? 1'b0 : w_jump;
  assign jump_addr_o   = rst ? ZeroWord : w_jump_addr;
  assign mc_timeout_o  = r_mc_timeout;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expected outputs queued at drive time, popped at sample.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_reg1_raddr_i;
  logic [4:0]  id_reg2_raddr_i;
  logic        ex_reg_we_i;
  logic [4:0]  ex_reg_waddr_i;
  logic        ex_is_load_i;
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_mc_start_i;
  logic        ex_mc_done_i;
  logic        mem_busy_i;
  logic [2:0]  hold_flag_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        mc_timeout_o;
  logic [31:0] stall_cnt_o;

  pipe_ctrl #(
    .MC_TIMEOUT (8),
    .CNT_W      (32)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_raddr_i (id_reg1_raddr_i),
    .id_reg2_raddr_i (id_reg2_raddr_i),
    .ex_reg_we_i     (ex_reg_we_i),
    .ex_reg_waddr_i  (ex_reg_waddr_i),
    .ex_is_load_i    (ex_is_load_i),
    .ex_jump_flag_i  (ex_jump_flag_i),
    .ex_jump_addr_i  (ex_jump_addr_i),
    .ex_mc_start_i   (ex_mc_start_i),
    .ex_mc_done_i    (ex_mc_done_i),
    .mem_busy_i      (mem_busy_i),
    .hold_flag_o     (hold_flag_o),
    .flush_if_id_o   (flush_if_id_o),
    .flush_id_ex_o   (flush_id_ex_o),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
    .mc_timeout_o    (mc_timeout_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [2:0]  hold;
    logic        fi;
    logic        fe;
    logic        jf;
    logic [31:0] ja;
    logic        tmo;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_cnt = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_reg1_raddr_i = '0;
    id_reg2_raddr_i = '0;
    ex_reg_we_i     = 1'b0;
    ex_reg_waddr_i  = '0;
    ex_is_load_i    = 1'b0;
    ex_jump_flag_i  = 1'b0;
    ex_jump_addr_i  = '0;
    ex_mc_start_i   = 1'b0;
    ex_mc_done_i    = 1'b0;
    mem_busy_i      = 1'b0;
  endtask

  // Drive a load in ex writing rd, with decode reading rs1/rs2.
  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ex_is_load_i    = 1'b1;
    ex_reg_we_i     = 1'b1;
    ex_reg_waddr_i  = rd;
    id_reg1_raddr_i = rs1;
    id_reg2_raddr_i = rs2;
  endtask

  task automatic set_jump(input logic [31:0] addr);
    ex_jump_flag_i = 1'b1;
    ex_jump_addr_i = addr;
  endtask

  task automatic push_exp(input string tag, input logic [2:0] hold, input logic fi,
                          input logic fe, input logic jf, input logic [31:0] ja,
                          input logic tmo);
    exp_t e;
    e.tag  = tag;
    e.hold = hold;
    e.fi   = fi;
    e.fe   = fe;
    e.jf   = jf;
    e.ja   = ja;
    e.tmo  = tmo;
    e.cnt  = m_cnt;
    sb_q.push_back(e);
    if (hold != 3'b000) m_cnt++;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty got 0 expected 1");
      return;
    end
    e = sb_q.pop_front();
    check_eq({e.tag, ".hold"}, 32'(hold_flag_o), 32'(e.hold));
    check_eq({e.tag, ".flush_if_id"}, 32'(flush_if_id_o), 32'(e.fi));
    check_eq({e.tag, ".flush_id_ex"}, 32'(flush_id_ex_o), 32'(e.fe));
    check_eq({e.tag, ".jump_flag"}, 32'(jump_flag_o), 32'(e.jf));
    check_eq({e.tag, ".jump_addr"}, jump_addr_o, e.ja);
    check_eq({e.tag, ".mc_timeout"}, 32'(mc_timeout_o), 32'(e.tmo));
    check_eq({e.tag, ".stall_cnt"}, stall_cnt_o, e.cnt);
  endtask

  // One cycle: inputs already driven just after the edge; sample mid-cycle, then advance.
  task automatic cyc(input string tag, input logic [2:0] hold, input logic fi, input logic fe,
                     input logic jf, input logic [31:0] ja, input logic tmo);
    push_exp(tag, hold, fi, fe, jf, ja, tmo);
    #3;
    compare_out();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic mc_start();
    ex_mc_start_i = 1'b1;
    cyc("mc_start", 3'b000, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mem_busy_i = 1'b1;
    set_jump(32'h0000_0100);
    #1;
    push_exp("reset", 3'b000, 0, 0, 0, 0, 0);
    #3;
    compare_out();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    cyc("idle", 3'b000, 0, 0, 0, 0, 0);

    set_lu(5'd5, 5'd5, 5'd0);
    cyc("lu_rs1", 3'b011, 0, 1, 0, 0, 0);
    set_lu(5'd5, 5'd5, 5'd0);
    cyc("lu_bub", 3'b000, 0, 0, 0, 0, 0);
    cyc("lu_run", 3'b000, 0, 0, 0, 0, 0);
    set_lu(5'd7, 5'd0, 5'd7);
    cyc("lu_rs2", 3'b011, 0, 1, 0, 0, 0);
    cyc("lu_rs2_bub", 3'b000, 0, 0, 0, 0, 0);

    set_lu(5'd0, 5'd0, 5'd0);
    cyc("x0_load", 3'b000, 0, 0, 0, 0, 0);
    set_lu(5'd5, 5'd5, 5'd0);
    ex_is_load_i = 1'b0;
    cyc("not_load", 3'b000, 0, 0, 0, 0, 0);
    set_lu(5'd5, 5'd5, 5'd0);
    ex_reg_we_i = 1'b0;
    cyc("no_we", 3'b000, 0, 0, 0, 0, 0);
    set_lu(5'd5, 5'd6, 5'd7);
    cyc("no_match", 3'b000, 0, 0, 0, 0, 0);

    set_lu(5'd5, 5'd5, 5'd0);
    set_jump(32'h0000_0100);
    cyc("jmp_lu", 3'b000, 1, 1, 1, 32'h0000_0100, 0);
    set_lu(5'd5, 5'd5, 5'd0);
    cyc("post_jmp_run", 3'b011, 0, 1, 0, 0, 0);
    set_jump(32'h0000_0200);
    cyc("bub_jmp", 3'b000, 1, 1, 1, 32'h0000_0200, 0);
    set_lu(5'd9, 5'd0, 5'd9);
    cyc("bub_jmp_run", 3'b011, 0, 1, 0, 0, 0);
    cyc("bub2", 3'b000, 0, 0, 0, 0, 0);

    mem_busy_i = 1'b1;
    set_lu(5'd5, 5'd5, 5'd0);
    set_jump(32'h0000_0300);
    ex_mc_start_i = 1'b1;
    cyc("busy_run", 3'b111, 0, 0, 0, 0, 0);
    cyc("post_busy", 3'b000, 0, 0, 0, 0, 0);

    mc_start();
    for (int i = 0; i < 4; i++) begin
      set_jump(32'h0000_0400);
      set_lu(5'd5, 5'd5, 5'd0);
      cyc("mc_wait", 3'b111, 0, 0, 0, 0, 0);
    end
    ex_mc_done_i = 1'b1;
    cyc("mc_done", 3'b000, 0, 0, 0, 0, 0);
    cyc("mc_after", 3'b000, 0, 0, 0, 0, 0);

    mc_start();
    for (int i = 0; i < 7; i++) cyc("tmo_wait", 3'b111, 0, 0, 0, 0, 0);
    cyc("tmo_term", 3'b000, 0, 1, 0, 0, 0);
    set_lu(5'd3, 5'd3, 5'd0);
    cyc("tmo_pulse", 3'b011, 0, 1, 0, 0, 1);
    cyc("tmo_after", 3'b000, 0, 0, 0, 0, 0);

    mc_start();
    for (int i = 0; i < 7; i++) cyc("dt_wait", 3'b111, 0, 0, 0, 0, 0);
    ex_mc_done_i = 1'b1;
    cyc("dt_done", 3'b000, 0, 0, 0, 0, 0);
    cyc("dt_nopulse", 3'b000, 0, 0, 0, 0, 0);

    mc_start();
    for (int i = 0; i < 2; i++) cyc("frz_wait", 3'b111, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      mem_busy_i = 1'b1;
      ex_mc_done_i = 1'b1;
      cyc("frz_busy", 3'b111, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) cyc("frz_rest", 3'b111, 0, 0, 0, 0, 0);
    cyc("frz_term", 3'b000, 0, 1, 0, 0, 0);
    cyc("frz_pulse", 3'b000, 0, 0, 0, 0, 1);

    mc_start();
    for (int i = 0; i < 2; i++) cyc("rst_wait", 3'b111, 0, 0, 0, 0, 0);
    push_exp("pre_rst", 3'b111, 0, 0, 0, 0, 0);
    #2;
    compare_out();
    rst = 1'b1;
    m_cnt = '0;
    #1;
    push_exp("rst_async", 3'b000, 0, 0, 0, 0, 0);
    compare_out();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_lu(5'd4, 5'd4, 5'd0);
    cyc("post_rst_run", 3'b011, 0, 1, 0, 0, 0);
    cyc("post_rst_bub", 3'b000, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
